fact_seq_ctrl: RTL and testbench

Sequencing controller for the iterative factorial datapath: a down-counter, a product register, a 2:1 mux selecting the initial value or the multiplier output, an output register, and a counter>1 comparator.
- Accepts a start request with operand N over a 4-phase GO/DONE handshake.
- Range-checks N before starting, then drives the load/enable/select strobes until the counter reaches 1.
- Reports completion or error, and includes a watchdog against a stuck comparator.

---
 rtl/fact_pkg.sv | 59 +++++
 rtl/fact_seq_ctrl_if.sv | 27 ++
 rtl/fact_watchdog.sv | 36 +++
 rtl/fact_seq_ctrl.sv | 82 ++++++++
 tb/tb_fact_seq_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fact_pkg.sv
// Shared definitions for the factorial sequencer: state encoding, default limits
// and the bit layout of the registered output/strobe bundle.
package fact_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_MULT   = 3'd3,
    ST_FINISH = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam int N_MAX_DEF    = 12;
  localparam int MAX_ITER_DEF = 12;

  localparam int STB_W       = 8;
  localparam int STB_MUX_SEL = 0;
  localparam int STB_REG_LD  = 1;
  localparam int STB_CNT_LD  = 2;
  localparam int STB_CNT_EN  = 3;
  localparam int STB_OUT_LD  = 4;
  localparam int STB_BUSY    = 5;
  localparam int STB_DONE    = 6;
  localparam int STB_ERR     = 7;

  // Moore decode: every output is a pure function of the state it accompanies.
  function automatic logic [STB_W-1:0] decode_strobes(state_t s);
    logic [STB_W-1:0] b;
    b = '0;
    case (s)
      ST_LOAD: begin
        b[STB_MUX_SEL] = 1'b1;
        b[STB_REG_LD]  = 1'b1;
        b[STB_CNT_LD]  = 1'b1;
        b[STB_BUSY]    = 1'b1;
      end
      ST_CHECK: b[STB_BUSY] = 1'b1;
      ST_MULT: begin
        b[STB_REG_LD] = 1'b1;
        b[STB_CNT_EN] = 1'b1;
        b[STB_BUSY]   = 1'b1;
      end
      ST_FINISH: begin
        b[STB_OUT_LD] = 1'b1;
        b[STB_BUSY]   = 1'b1;
      end
      ST_DONE: b[STB_DONE] = 1'b1;
      ST_ERROR: begin
        b[STB_DONE] = 1'b1;
        b[STB_ERR]  = 1'b1;
      end
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/fact_seq_ctrl_if.sv
// GO/DONE handshake plus the datapath strobe bundle between the factorial
// sequencer (slave) and its requester/datapath (master).
interface fact_seq_ctrl_if #(
  parameter int N_W = 4
);
  logic           GO;
  logic [N_W-1:0] N;
  logic           GT;
  logic           BUSY;
  logic           DONE;
  logic           ERR;
  logic           MUX_SEL;
  logic           REG_LD;
  logic           CNT_LD;
  logic           CNT_EN;
  logic           OUT_LD;

  modport master (
    output GO, N, GT,
    input  BUSY, DONE, ERR, MUX_SEL, REG_LD, CNT_LD, CNT_EN, OUT_LD
  );

  modport slave (
    input  GO, N, GT,
    output BUSY, DONE, ERR, MUX_SEL, REG_LD, CNT_LD, CNT_EN, OUT_LD
  );
endinterface

// File: rtl/fact_watchdog.sv
// Counts MULT iterations of one run and flags when the limit is reached, guarding
// against a comparator that never deasserts.
module fact_watchdog #(
  parameter int ITER_W   = 4,
  parameter int MAX_ITER = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  logic [ITER_W-1:0] iter_q, iter_d;

  // Saturating increment so a stuck run can never wrap back below the limit.
  always_comb begin
    iter_d = iter_q;
    if (clr) begin
      iter_d = '0;
    end else if (inc && (iter_q != '1)) begin
      iter_d = iter_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

  assign at_limit = (iter_q == ITER_W'(MAX_ITER));

endmodule

// File: rtl/fact_seq_ctrl.sv
// Sequencing FSM for the iterative factorial datapath: range check, LOAD/CHECK/MULT
// loop, result hand-off and GO/DONE handshake, with registered Moore outputs.
module fact_seq_ctrl
  import fact_pkg::*;
#(
  parameter int N_W      = 4,
  parameter int N_MAX    = N_MAX_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF,
  parameter int ITER_W   = 4
) (
  input  logic            CLK,
  input  logic            RST,
  fact_seq_ctrl_if.slave  bus
);

  state_t           state_q, state_d;
  logic [STB_W-1:0] stb_q, stb_d;
  logic             iter_at_limit;

  fact_watchdog #(
    .ITER_W   (ITER_W),
    .MAX_ITER (MAX_ITER)
  ) u_watchdog (
    .clk      (CLK),
    .rst      (RST),
    .clr      (state_q == ST_LOAD),
    .inc      (state_q == ST_MULT),
    .at_limit (iter_at_limit)
  );

  // Outputs are decoded from the next state and registered with it, so they
  // always line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.GO) begin
          state_d = (bus.N > N_W'(N_MAX)) ? ST_ERROR : ST_LOAD;
        end
      end
      ST_LOAD:   state_d = ST_CHECK;
      ST_CHECK: begin
        if (!bus.GT) begin
          state_d = ST_FINISH;
        end else if (iter_at_limit) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_MULT;
        end
      end
      ST_MULT:   state_d = ST_CHECK;
      ST_FINISH: state_d = ST_DONE;
      ST_DONE, ST_ERROR: begin
        if (!bus.GO) begin
          state_d = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
    stb_d = decode_strobes(state_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      stb_q   <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
    end
  end

  assign bus.MUX_SEL = stb_q[STB_MUX_SEL];
  assign bus.REG_LD  = stb_q[STB_REG_LD];
  assign bus.CNT_LD  = stb_q[STB_CNT_LD];
  assign bus.CNT_EN  = stb_q[STB_CNT_EN];
  assign bus.OUT_LD  = stb_q[STB_OUT_LD];
  assign bus.BUSY    = stb_q[STB_BUSY];
  assign bus.DONE    = stb_q[STB_DONE];
  assign bus.ERR     = stb_q[STB_ERR];

endmodule

// File: tb/tb_fact_seq_ctrl.sv
// Bench for fact_seq_ctrl: drives runs through the GO/DONE handshake against a small
// datapath model and compares timing, strobe counts and results with arithmetic expectations.
module tb_fact_seq_ctrl;

  localparam int N_W        = 4;
  localparam int N_MAX      = 12;
  localparam int MAX_ITER   = 12;
  localparam int MAX_CYCLES = 80;

  logic           CLK = 1'b0;
  logic           RST;
  bit             force_gt = 1'b0;
  logic [N_W-1:0] cnt_m;
  logic [31:0]    prod_m;
  logic [31:0]    out_m;
  int             checks = 0;
  int             errors = 0;

  fact_seq_ctrl_if #(.N_W(N_W)) bus ();

  fact_seq_ctrl #(
    .N_W      (N_W),
    .N_MAX    (N_MAX),
    .MAX_ITER (MAX_ITER),
    .ITER_W   (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  assign bus.GT = force_gt ? 1'b1 : (cnt_m > N_W'(1));

  // Datapath model: down-counter, product register with 2:1 mux, output register.
  always @(posedge CLK) begin
    if (RST) begin
      cnt_m  <= '0;
      prod_m <= '0;
      out_m  <= '0;
    end else begin
      if (bus.CNT_LD) cnt_m <= bus.N;
      else if (bus.CNT_EN) cnt_m <= cnt_m - 1'b1;
      if (bus.REG_LD) prod_m <= bus.MUX_SEL ? 32'd1 : prod_m * 32'(cnt_m);
      if (bus.OUT_LD) out_m <= prod_m;
    end
  end

  function automatic logic [7:0] outs();
    return {bus.ERR, bus.DONE, bus.BUSY, bus.OUT_LD,
            bus.CNT_EN, bus.CNT_LD, bus.REG_LD, bus.MUX_SEL};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [N_W-1:0] n, input bit gt_stuck, input int hold,
                                input bit drop_early, input int rst_cycle);
    int          c, done_c, reg_ld_n, cnt_en_n, cnt_ld_n, out_ld_n, busy_n;
    int          cnt_ld_c, out_ld_c, hold_bad, k;
    int          exp_done, exp_reg_ld, exp_cnt_en, exp_cnt_ld, exp_out_ld, exp_out_c, exp_cnt_ld_c;
    logic        err_seen, exp_err;
    logic [7:0]  o;
    logic [31:0] exp_fact;
    bit          range_err, wd_err;

    range_err = (int'(n) > N_MAX);
    wd_err    = !range_err && gt_stuck;
    k         = (n > 1) ? int'(n) - 1 : 0;
    exp_fact  = 32'd1;
    for (int i = 2; i <= int'(n); i++) exp_fact = exp_fact * 32'(i);
    if (range_err) begin
      exp_done = 1; exp_reg_ld = 0; exp_cnt_en = 0; exp_cnt_ld = 0;
      exp_out_ld = 0; exp_out_c = -1; exp_cnt_ld_c = -1; exp_err = 1'b1;
    end else if (wd_err) begin
      exp_done = 3 + 2 * MAX_ITER; exp_reg_ld = MAX_ITER + 1; exp_cnt_en = MAX_ITER;
      exp_cnt_ld = 1; exp_out_ld = 0; exp_out_c = -1; exp_cnt_ld_c = 1; exp_err = 1'b1;
    end else begin
      exp_done = 4 + 2 * k; exp_reg_ld = k + 1; exp_cnt_en = k; exp_cnt_ld = 1;
      exp_out_ld = 1; exp_out_c = 3 + 2 * k; exp_cnt_ld_c = 1; exp_err = 1'b0;
    end

    force_gt = gt_stuck;
    bus.N    = n;
    bus.GO   = 1'b1;
    c = 0; done_c = -1; reg_ld_n = 0; cnt_en_n = 0; cnt_ld_n = 0; out_ld_n = 0;
    busy_n = 0; cnt_ld_c = -1; out_ld_c = -1; err_seen = 1'b0;

    while (done_c < 0 && c < MAX_CYCLES) begin
      @(negedge CLK);
      c++;
      o = outs();
      if (rst_cycle != 0 && c == rst_cycle) begin
        RST    = 1'b1;
        bus.GO = 1'b0;
        @(negedge CLK);
        check_output("rst_mid_run_idle", 32'(outs()), 32'd0);
        RST      = 1'b0;
        force_gt = 1'b0;
        return;
      end
      if (o[1]) reg_ld_n++;
      if (o[3]) cnt_en_n++;
      if (o[2]) begin
        cnt_ld_n++;
        if (cnt_ld_c < 0) cnt_ld_c = c;
      end
      if (o[4]) begin
        out_ld_n++;
        if (out_ld_c < 0) out_ld_c = c;
      end
      if (o[5]) busy_n++;
      if (o[6]) begin
        done_c   = c;
        err_seen = o[7];
      end
      if (drop_early && c == 2) bus.GO = 1'b0;
      if (c >= 2) bus.N = N_W'($urandom);
    end

    check_output("done_cycle", 32'(done_c), 32'(exp_done));
    if (done_c < 0) begin
      RST = 1'b1; bus.GO = 1'b0; force_gt = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      return;
    end
    check_output("err", 32'(err_seen), 32'(exp_err));
    check_output("reg_ld_count", 32'(reg_ld_n), 32'(exp_reg_ld));
    check_output("cnt_en_count", 32'(cnt_en_n), 32'(exp_cnt_en));
    check_output("cnt_ld_count", 32'(cnt_ld_n), 32'(exp_cnt_ld));
    check_output("cnt_ld_cycle", 32'(cnt_ld_c), 32'(exp_cnt_ld_c));
    check_output("out_ld_count", 32'(out_ld_n), 32'(exp_out_ld));
    check_output("out_ld_cycle", 32'(out_ld_c), 32'(exp_out_c));
    check_output("busy_cycles", 32'(busy_n), 32'(exp_done - 1));
    if (!range_err && !wd_err) check_output("product", out_m, exp_fact);

    hold_bad = 0;
    if (!drop_early) begin
      repeat (hold) begin
        @(negedge CLK);
        o = outs();
        if (!(o[6] && (o[7] == exp_err) && (o[5:0] == 6'd0))) hold_bad++;
      end
      check_output("done_hold_stable", 32'(hold_bad), 32'd0);
    end
    bus.GO   = 1'b0;
    force_gt = 1'b0;
    @(negedge CLK);
    check_output("idle_after_go_low", 32'(outs()), 32'd0);
  endtask

  initial begin
    RST    = 1'b1;
    bus.GO = 1'b0;
    bus.N  = '0;
    repeat (2) @(negedge CLK);
    check_output("reset_outputs", 32'(outs()), 32'd0);
    RST = 1'b0;

    apply_stimulus(4'd5,  1'b0, 1, 1'b0, 0);
    apply_stimulus(4'd0,  1'b0, 0, 1'b0, 0);
    apply_stimulus(4'd1,  1'b0, 0, 1'b0, 0);
    apply_stimulus(4'd13, 1'b0, 2, 1'b0, 0);
    apply_stimulus(4'd12, 1'b1, 1, 1'b0, 0);
    apply_stimulus(4'd8,  1'b0, 0, 1'b0, 6);
    apply_stimulus(4'd3,  1'b0, 0, 1'b0, 0);
    apply_stimulus(4'd7,  1'b0, 5, 1'b0, 0);
    apply_stimulus(4'd4,  1'b0, 0, 1'b0, 0);
    apply_stimulus(4'd12, 1'b0, 0, 1'b0, 0);
    apply_stimulus(4'd6,  1'b0, 0, 1'b1, 0);
    apply_stimulus(4'd15, 1'b1, 0, 1'b0, 0);

    for (int r = 0; r < 40; r++) begin
      apply_stimulus(N_W'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
                     int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
